// File: rtl/ct_lsu_pfu_sdb_stride_trainer.sv
// Per-entry stride trainer for the LSU prefetch unit.
// Captures PC/VA on create, learns a signed stride from same-PC loads and
// keeps a saturating confidence count that drives activation.
// Optional feature macro: PFU_SDB_NEG_STRIDE_EN enables negative strides.
module ct_lsu_pfu_sdb_stride_trainer #(
  parameter int unsigned CONF_WIDTH  = 2,
  parameter int unsigned CONF_THRESH = 2
) (
  input  logic        entry_clk,
  input  logic        cpurst_b,
  input  logic        entry_create_vld,
  input  logic        entry_pop_vld,
  input  logic        entry_train_vld,
  input  logic [14:0] pipe_pc,
  input  logic [39:0] pipe_va,
  output logic        entry_vld,
  output logic        entry_pc_hit,
  output logic [10:0] entry_stride,
  output logic        entry_stride_neg,
  output logic        entry_act_vld,
  output logic        entry_reinit_vld,
  output logic        entry_pf_inst_vld
);

  typedef enum logic [1:0] {StIdle, StTrain, StStride} state_e;

  state_e                state_q, state_d;
  logic                  vld_q, vld_d;
  logic [14:0]           pc_q, pc_d;
  logic [39:0]           last_va_q, last_va_d;
  logic [11:0]           stride_q, stride_d;
  logic [CONF_WIDTH-1:0] conf_q, conf_d;
  logic                  act_q, act_d;
  logic                  reinit_q, reinit_d;
  logic                  pf_q, pf_d;

  logic [39:0] delta;
  logic        delta_zero;
  logic        delta_in_range;
  logic        stride_match;
  logic        train_hit;

  // Delta classification against the last trained VA
  always_comb begin
    delta      = pipe_va - last_va_q;
    delta_zero = (delta == '0);
`ifdef PFU_SDB_NEG_STRIDE_EN
    delta_in_range = (delta[39:12] == {28{delta[11]}});
`else
    // Negative deltas (bit 39 set) fall out of range here.
    delta_in_range = (delta[39:11] == '0);
`endif
    stride_match = delta_in_range && (delta[11:0] == stride_q);
    entry_pc_hit = vld_q && (pipe_pc == pc_q);
    train_hit    = entry_train_vld && entry_pc_hit;
  end

  // Next-state logic: pop beats create beats train
  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    pc_d      = pc_q;
    last_va_d = last_va_q;
    stride_d  = stride_q;
    conf_d    = conf_q;
    reinit_d  = 1'b0;
    pf_d      = 1'b0;
    if (entry_pop_vld) begin
      state_d = StIdle;
      vld_d   = 1'b0;
      conf_d  = '0;
    end else if (entry_create_vld) begin
      state_d   = StTrain;
      vld_d     = 1'b1;
      pc_d      = pipe_pc;
      last_va_d = pipe_va;
      stride_d  = '0;
      conf_d    = '0;
    end else if (train_hit && !delta_zero) begin
      last_va_d = pipe_va;
      unique case (state_q)
        StTrain: begin
          if (delta_in_range) begin
            state_d  = StStride;
            stride_d = delta[11:0];
            conf_d   = '0;
          end
        end
        StStride: begin
          if (stride_match) begin
            conf_d = (conf_q == '1) ? conf_q : conf_q + 1'b1;
            pf_d   = act_q;
          end else if (delta_in_range) begin
            stride_d = delta[11:0];
            conf_d   = '0;
            reinit_d = act_q;
          end else begin
            state_d  = StTrain;
            conf_d   = '0;
            reinit_d = act_q;
          end
        end
        default: ;
      endcase
    end
    act_d = (state_d == StStride) && (conf_d >= CONF_WIDTH'(CONF_THRESH));
  end

  // State and registered outputs
  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= StIdle;
      vld_q     <= 1'b0;
      pc_q      <= '0;
      last_va_q <= '0;
      stride_q  <= '0;
      conf_q    <= '0;
      act_q     <= 1'b0;
      reinit_q  <= 1'b0;
      pf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      pc_q      <= pc_d;
      last_va_q <= last_va_d;
      stride_q  <= stride_d;
      conf_q    <= conf_d;
      act_q     <= act_d;
      reinit_q  <= reinit_d;
      pf_q      <= pf_d;
    end
  end

  assign entry_vld         = vld_q;
  assign entry_stride      = stride_q[10:0];
`ifdef PFU_SDB_NEG_STRIDE_EN
  assign entry_stride_neg  = stride_q[11];
`else
  assign entry_stride_neg  = 1'b0;
`endif
  assign entry_act_vld     = act_q;
  assign entry_reinit_vld  = reinit_q;
  assign entry_pf_inst_vld = pf_q;

endmodule

// File: tb/tb_ct_lsu_pfu_sdb_stride_trainer.sv
// Self-checking bench for ct_lsu_pfu_sdb_stride_trainer: directed vector table,
// hand-written negative-stride and async-reset sequences, then random traffic
// against a rule-level reference model.
module tb_ct_lsu_pfu_sdb_stride_trainer;

  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic        entry_clk = 1'b0;
  logic        cpurst_b;
  logic        entry_create_vld, entry_pop_vld, entry_train_vld;
  logic [14:0] pipe_pc;
  logic [39:0] pipe_va;
  logic        entry_vld, entry_pc_hit, entry_stride_neg;
  logic [10:0] entry_stride;
  logic        entry_act_vld, entry_reinit_vld, entry_pf_inst_vld;

  int checks = 0;
  int errors = 0;

  ct_lsu_pfu_sdb_stride_trainer #(.CONF_WIDTH(2), .CONF_THRESH(2)) dut (
    .entry_clk         (entry_clk),
    .cpurst_b          (cpurst_b),
    .entry_create_vld  (entry_create_vld),
    .entry_pop_vld     (entry_pop_vld),
    .entry_train_vld   (entry_train_vld),
    .pipe_pc           (pipe_pc),
    .pipe_va           (pipe_va),
    .entry_vld         (entry_vld),
    .entry_pc_hit      (entry_pc_hit),
    .entry_stride      (entry_stride),
    .entry_stride_neg  (entry_stride_neg),
    .entry_act_vld     (entry_act_vld),
    .entry_reinit_vld  (entry_reinit_vld),
    .entry_pf_inst_vld (entry_pf_inst_vld)
  );

  always #5 entry_clk = ~entry_clk;

  typedef struct {
    bit          cr, pp, tr;
    logic [14:0] pc;
    logic [39:0] va;
    bit          hit, vld;
    logic [11:0] strd;
    bit          chk_strd;
    bit          act, re, pf;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit c, input bit p, input bit t, input logic [14:0] pc,
                       input logic [39:0] va);
    entry_create_vld = c;
    entry_pop_vld    = p;
    entry_train_vld  = t;
    pipe_pc          = pc;
    pipe_va          = va;
    #2;
  endtask

  task automatic tick();
    @(posedge entry_clk);
    #1;
  endtask

  function automatic logic [11:0] dut_stride12();
    return {entry_stride_neg, entry_stride};
  endfunction

  // Reference model: plain arithmetic on a signed delta
  int          m_state;  // 0 idle, 1 waiting for first stride, 2 stride known
  bit          m_vld, m_act, m_re, m_pf;
  logic [14:0] m_pc;
  logic [39:0] m_last;
  int          m_stride;
  int          m_conf;

  function automatic bit in_range(longint d);
`ifdef PFU_SDB_NEG_STRIDE_EN
    return d >= -2048 && d <= 2047;
`else
    return d >= 0 && d <= 2047;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_vld = 0; m_act = 0; m_re = 0; m_pf = 0;
    m_pc = '0; m_last = '0; m_stride = 0; m_conf = 0;
  endtask

  task automatic model_step(input bit c, input bit p, input bit t, input logic [14:0] pc,
                            input logic [39:0] va);
    bit          hit;
    logic [39:0] raw;
    longint      d;
    hit  = t && m_vld && (pc == m_pc);
    raw  = va - m_last;
    d    = longint'($signed(raw));
    m_re = 0;
    m_pf = 0;
    if (p) begin
      m_state = 0; m_vld = 0; m_conf = 0;
    end else if (c) begin
      m_state = 1; m_vld = 1; m_pc = pc; m_last = va; m_conf = 0; m_stride = 0;
    end else if (hit && d != 0) begin
      if (m_state == 1) begin
        if (in_range(d)) begin
          m_state = 2; m_stride = int'(d); m_conf = 0;
        end
      end else if (m_state == 2) begin
        if (in_range(d) && d == longint'(m_stride)) begin
          if (m_conf < 3) m_conf++;
          m_pf = m_act;
        end else if (in_range(d)) begin
          m_stride = int'(d); m_conf = 0; m_re = m_act;
        end else begin
          m_state = 1; m_conf = 0; m_re = m_act;
        end
      end
      m_last = va;
    end
    m_act = (m_state == 2) && (m_conf >= 2);
  endtask

  initial begin
    logic [11:0] exp_neg;
    vecs[0]  = '{T,F,F,15'h12,40'h1000, F,T,12'h000,T, F,F,F};
    vecs[1]  = '{F,F,T,15'h12,40'h1040, T,T,12'h040,T, F,F,F};
    vecs[2]  = '{F,F,T,15'h12,40'h1080, T,T,12'h040,T, F,F,F};
    vecs[3]  = '{F,F,T,15'h12,40'h10C0, T,T,12'h040,T, T,F,F};
    vecs[4]  = '{F,F,T,15'h12,40'h1100, T,T,12'h040,T, T,F,T};
    vecs[5]  = '{F,F,T,15'h12,40'h1140, T,T,12'h040,T, T,F,T};
    vecs[6]  = '{F,F,F,15'h12,40'h1140, T,T,12'h040,T, T,F,F};
    vecs[7]  = '{F,F,T,15'h12,40'h11C0, T,T,12'h080,T, F,T,F};
    vecs[8]  = '{F,F,T,15'h12,40'h1240, T,T,12'h080,T, F,F,F};
    vecs[9]  = '{F,F,T,15'h12,40'h12C0, T,T,12'h080,T, T,F,F};
    vecs[10] = '{F,F,T,15'h12,40'h1340, T,T,12'h080,T, T,F,T};
    vecs[11] = '{F,F,T,15'h12,40'h2340, T,T,12'h080,F, F,T,F};
    vecs[12] = '{F,F,T,15'h12,40'h2340, T,T,12'h080,F, F,F,F};
    vecs[13] = '{F,F,T,15'h12,40'h2380, T,T,12'h040,T, F,F,F};
    vecs[14] = '{F,F,T,15'h13,40'h23C0, F,T,12'h040,T, F,F,F};
    vecs[15] = '{F,F,T,15'h12,40'h23C0, T,T,12'h040,T, F,F,F};
    vecs[16] = '{F,F,T,15'h12,40'h2400, T,T,12'h040,T, T,F,F};
    vecs[17] = '{F,T,T,15'h12,40'h2440, T,F,12'h040,F, F,F,F};
    vecs[18] = '{T,F,F,15'h12,40'h5000, F,T,12'h000,T, F,F,F};
    vecs[19] = '{T,T,F,15'h12,40'h6000, T,F,12'h000,F, F,F,F};

    // Reset state
    cpurst_b = 1'b0;
    drive(F, F, F, 15'h0, 40'h0);
    #10;
    check("rst_vld", 64'(entry_vld), 64'd0);
    check("rst_stride", 64'(dut_stride12()), 64'd0);
    check("rst_act", 64'(entry_act_vld), 64'd0);
    check("rst_pulses", 64'({entry_reinit_vld, entry_pf_inst_vld}), 64'd0);
    @(negedge entry_clk);
    cpurst_b = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].cr, vecs[i].pp, vecs[i].tr, vecs[i].pc, vecs[i].va);
      check($sformatf("v%0d_pc_hit", i), 64'(entry_pc_hit), 64'(vecs[i].hit));
      tick();
      check($sformatf("v%0d_vld", i), 64'(entry_vld), 64'(vecs[i].vld));
      if (vecs[i].chk_strd)
        check($sformatf("v%0d_stride", i), 64'(dut_stride12()), 64'(vecs[i].strd));
      check($sformatf("v%0d_act", i), 64'(entry_act_vld), 64'(vecs[i].act));
      check($sformatf("v%0d_reinit", i), 64'(entry_reinit_vld), 64'(vecs[i].re));
      check($sformatf("v%0d_pf", i), 64'(entry_pf_inst_vld), 64'(vecs[i].pf));
    end

    // Negative stride sequence
    drive(T, F, F, 15'h21, 40'h2000); tick();
    drive(F, F, T, 15'h21, 40'h1FC0); tick();
    drive(F, F, T, 15'h21, 40'h1F80); tick();
    drive(F, F, T, 15'h21, 40'h1F40); tick();
`ifdef PFU_SDB_NEG_STRIDE_EN
    exp_neg = 12'hFC0;
    check("neg_act", 64'(entry_act_vld), 64'd1);
`else
    exp_neg = 12'h000;
    check("neg_act", 64'(entry_act_vld), 64'd0);
`endif
    check("neg_stride", 64'(dut_stride12()), 64'(exp_neg));

    // Async reset while active
    drive(T, F, F, 15'h33, 40'h8000); tick();
    for (int k = 1; k <= 3; k++) begin
      drive(F, F, T, 15'h33, 40'h8000 + 40'(k * 'h40)); tick();
    end
    drive(F, F, F, 15'h33, 40'h80C0);
    check("pre_rst_act", 64'(entry_act_vld), 64'd1);
    cpurst_b = 1'b0;
    #1;
    check("async_rst_out", 64'({entry_vld, entry_pc_hit, entry_act_vld, entry_reinit_vld,
                                entry_pf_inst_vld, dut_stride12()}), 64'd0);
    @(negedge entry_clk);
    cpurst_b = 1'b1;
    model_reset();
    tick();

    // Random traffic vs reference model
    for (int n = 0; n < 3000; n++) begin
      bit          c, p, t;
      logic [14:0] pc;
      logic [39:0] va;
      int          kind;
      c = ($urandom_range(0, 15) == 0);
      p = ($urandom_range(0, 31) == 0);
      t = ($urandom_range(0, 3) != 0);
      pc = ($urandom_range(0, 3) != 0) ? m_pc : 15'($urandom_range(0, 3) + 'h12);
      kind = $urandom_range(0, 9);
      case (kind)
        0:       va = m_last;
        1, 2, 3, 4: va = m_last + 40'(m_stride);
        5:       va = m_last + 40'($signed($urandom_range(0, 4095)) - 2048);
        6:       va = m_last + 40'($urandom_range(1, 127) * 'h40);
        7:       va = m_last + 40'h1000;
        8:       va = {8'($urandom), 32'($urandom)};
        default: va = m_last - 40'($urandom_range(1, 4) * 'h40);
      endcase
      drive(c, p, t, pc, va);
      check("rnd_pc_hit", 64'(entry_pc_hit), 64'(m_vld && (pc == m_pc)));
      model_step(c, p, t, pc, va);
      tick();
      check("rnd_vld", 64'(entry_vld), 64'(m_vld));
      check("rnd_stride", 64'(dut_stride12()), 64'(12'(m_stride)));
      check("rnd_act", 64'(entry_act_vld), 64'(m_act));
      check("rnd_reinit", 64'(entry_reinit_vld), 64'(m_re));
      check("rnd_pf", 64'(entry_pf_inst_vld), 64'(m_pf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
